bof_range_checker: RTL and testbench

- Reader-side counterpart to the heap overflow tracker.
- Holds a circular table of completed overflow ranges {start, end} pushed by the tracker.
- Answers load-address range queries through a multi-cycle scan engine with valid/ready handshakes on both request and response.
- Sits beside the load unit; a response with hit_o=1 feeds the crash/alert logic.

---
 rtl/bop_pkg.sv | 37 +++
 rtl/bof_range_table.sv | 62 ++++++
 rtl/bof_range_checker.sv | 184 ++++++++++++++++++
 tb/tb_bof_range_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bop_pkg.sv
// Shared types and constants for the overflow range checker slice.
//   range_entry_t : one stored overflow range {start, end_addr, big, valid}
//   scan_state_e  : scan engine states
//   size_bytes()  : access size decode; unsupported encodings read as 1 byte
package bop_pkg;

  localparam int unsigned ENTRY_AW          = 32;
  localparam int unsigned ADDR_W_DEF        = ENTRY_AW;
  localparam int unsigned NUM_ENTRIES_DEF   = 8;
  localparam int unsigned BIG_THRESHOLD_DEF = 100;

  localparam logic [2:0] SIZE_1 = 3'd1;
  localparam logic [2:0] SIZE_2 = 3'd2;
  localparam logic [2:0] SIZE_4 = 3'd4;

  typedef struct packed {
    logic [ENTRY_AW-1:0] start;
    logic [ENTRY_AW-1:0] end_addr;
    logic                big;
    logic                valid;
  } range_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } scan_state_e;

  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SIZE_2:  size_bytes = SIZE_2;
      SIZE_4:  size_bytes = SIZE_4;
      default: size_bytes = SIZE_1;
    endcase
  endfunction

endpackage

// File: rtl/bof_range_table.sv
// Circular table of completed overflow ranges.
//   clk_i, rst_ni        : clock, async active-low reset
//   flush_i              : clear all valid bits, write pointer and count
//   wr_valid_i/start/end : push one range; inverted ranges are dropped
//   rd_idx_i, rd_entry_c : combinational read port used by the scan engine
//   wptr_o, count_o      : next write slot and occupancy (registered)
module bof_range_table
  import bop_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES   = NUM_ENTRIES_DEF,
  parameter int unsigned BIG_THRESHOLD = BIG_THRESHOLD_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           wr_valid_i,
  input  logic [ENTRY_AW-1:0]            wr_start_i,
  input  logic [ENTRY_AW-1:0]            wr_end_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0] rd_idx_i,
  output range_entry_t                   rd_entry_c,
  output logic [$clog2(NUM_ENTRIES)-1:0] wptr_o,
  output logic [$clog2(NUM_ENTRIES):0]   count_o
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned LEN_W = ENTRY_AW + 1;

  range_entry_t       mem_q [NUM_ENTRIES];
  logic [IDX_W-1:0]   wptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               wr_ok;
  logic [LEN_W-1:0]   len_c;
  logic               big_c;

  // Length computed one bit wider so a full-span range cannot wrap to zero.
  assign wr_ok = wr_valid_i && (wr_end_i >= wr_start_i);
  assign len_c = LEN_W'(wr_end_i) - LEN_W'(wr_start_i) + LEN_W'(1);
  assign big_c = len_c > LEN_W'(BIG_THRESHOLD);

  // Storage, pointer and occupancy; flush beats a same-cycle write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) mem_q[i].valid <= 1'b0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (wr_ok) begin
      mem_q[wptr_q] <= '{start: wr_start_i, end_addr: wr_end_i, big: big_c, valid: 1'b1};
      wptr_q        <= wptr_q + IDX_W'(1);
      if (count_q != CNT_W'(NUM_ENTRIES)) count_q <= count_q + CNT_W'(1);
    end
  end

  assign rd_entry_c = mem_q[rd_idx_i];
  assign wptr_o     = wptr_q;
  assign count_o    = count_q;

endmodule

// File: rtl/bof_range_checker.sv
// Load-address range checker against recorded heap overflow ranges.
// Scans the range table newest-first, one entry per cycle, and returns the
// first overlapping entry through a valid/ready response.
//   clk_i, rst_ni                 : clock, async active-low reset
//   flush_i                       : clear table; aborts an active scan
//   wr_valid_i/wr_start_i/wr_end_i: range push from the overflow tracker
//   req_valid_i/req_ready_o       : lookup request handshake (addr, size)
//   resp_valid_o/resp_ready_i     : response handshake
//   resp_hit_o/first_o/big_o/idx_o: lookup result, held until accepted
//   count_o                       : occupied table entries
// ADDR_W must not exceed bop_pkg::ENTRY_AW (stored field width).
module bof_range_checker
  import bop_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES   = NUM_ENTRIES_DEF,
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned BIG_THRESHOLD = BIG_THRESHOLD_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           wr_valid_i,
  input  logic [ADDR_W-1:0]              wr_start_i,
  input  logic [ADDR_W-1:0]              wr_end_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [ADDR_W-1:0]              req_addr_i,
  input  logic [2:0]                     req_size_i,
  output logic                           resp_valid_o,
  input  logic                           resp_ready_i,
  output logic                           resp_hit_o,
  output logic                           resp_first_o,
  output logic                           resp_big_o,
  output logic [$clog2(NUM_ENTRIES)-1:0] resp_idx_o,
  output logic [$clog2(NUM_ENTRIES):0]   count_o
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned XW    = ADDR_W + 1;

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     last_q, last_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic              resp_first_q, resp_first_d;
  logic              resp_big_q, resp_big_d;
  logic [IDX_W-1:0]  resp_idx_q, resp_idx_d;

  range_entry_t      rd_entry;
  logic [IDX_W-1:0]  wptr;
  logic [CNT_W-1:0]  count;
  logic [XW-1:0]     addr_x, start_x, end_x;
  logic              hit_c, first_c;

  bof_range_table #(
    .NUM_ENTRIES  (NUM_ENTRIES),
    .BIG_THRESHOLD(BIG_THRESHOLD)
  ) u_table (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .wr_valid_i(wr_valid_i),
    .wr_start_i(ENTRY_AW'(wr_start_i)),
    .wr_end_i  (ENTRY_AW'(wr_end_i)),
    .rd_idx_i  (ptr_q),
    .rd_entry_c(rd_entry),
    .wptr_o    (wptr),
    .count_o   (count)
  );

  // Overlap test in ADDR_W+1 bits so addr+size-1 never wraps past zero.
  assign addr_x  = XW'(addr_q);
  assign start_x = XW'(rd_entry.start);
  assign end_x   = XW'(rd_entry.end_addr);
  assign hit_c   = rd_entry.valid && (addr_x <= end_x) && (last_q >= start_x);
  assign first_c = (addr_x == start_x);

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      last_q       <= '0;
      ptr_q        <= '0;
      left_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_first_q <= 1'b0;
      resp_big_q   <= 1'b0;
      resp_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      ptr_q        <= ptr_d;
      left_q       <= left_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_first_q <= resp_first_d;
      resp_big_q   <= resp_big_d;
      resp_idx_q   <= resp_idx_d;
    end
  end

  // Next-state and next-output logic for the scan engine.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    last_d       = last_q;
    ptr_d        = ptr_q;
    left_d       = left_q;
    resp_hit_d   = resp_hit_q;
    resp_first_d = resp_first_q;
    resp_big_d   = resp_big_q;
    resp_idx_d   = resp_idx_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d = req_addr_i;
          last_d = XW'(req_addr_i) + XW'(size_bytes(req_size_i)) - XW'(1);
          ptr_d  = wptr - IDX_W'(1);
          left_d = count;
          if (count == '0) begin
            state_d      = RESP;
            resp_hit_d   = 1'b0;
            resp_first_d = 1'b0;
            resp_big_d   = 1'b0;
            resp_idx_d   = '0;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (flush_i) begin
          state_d      = RESP;
          resp_hit_d   = 1'b0;
          resp_first_d = 1'b0;
          resp_big_d   = 1'b0;
          resp_idx_d   = '0;
        end else if (hit_c) begin
          state_d      = RESP;
          resp_hit_d   = 1'b1;
          resp_first_d = first_c;
          resp_big_d   = rd_entry.big;
          resp_idx_d   = ptr_q;
        end else if (left_q == CNT_W'(1)) begin
          state_d      = RESP;
          resp_hit_d   = 1'b0;
          resp_first_d = 1'b0;
          resp_big_d   = 1'b0;
          resp_idx_d   = '0;
        end else begin
          ptr_d  = ptr_q - IDX_W'(1);
          left_d = left_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_first_o = resp_first_q;
  assign resp_big_o   = resp_big_q;
  assign resp_idx_o   = resp_idx_q;
  assign count_o      = count;

endmodule

// File: tb/tb_bof_range_checker.sv
// Directed self-checking bench for bof_range_checker (8 entries, 32-bit).
module tb_bof_range_checker;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        wr_valid_i;
  logic [31:0] wr_start_i;
  logic [31:0] wr_end_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [2:0]  req_size_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic        resp_hit_o;
  logic        resp_first_o;
  logic        resp_big_o;
  logic [2:0]  resp_idx_o;
  logic [3:0]  count_o;

  int checks   = 0;
  int failures = 0;
  int lat;

  bof_range_checker #(
    .NUM_ENTRIES  (8),
    .ADDR_W       (32),
    .BIG_THRESHOLD(100)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .wr_valid_i  (wr_valid_i),
    .wr_start_i  (wr_start_i),
    .wr_end_i    (wr_end_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_size_i  (req_size_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_hit_o  (resp_hit_o),
    .resp_first_o(resp_first_o),
    .resp_big_o  (resp_big_o),
    .resp_idx_o  (resp_idx_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] s, input logic [31:0] e);
    @(negedge clk_i);
    wr_valid_i = 1'b1;
    wr_start_i = s;
    wr_end_i   = e;
    @(negedge clk_i);
    wr_valid_i = 1'b0;
  endtask

  task automatic flush_pulse();
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  // Drives one request; lat counts cycles from acceptance to resp_valid_o.
  task automatic issue(input logic [31:0] a, input logic [2:0] sz, output int l);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_size_i  = sz;
    l = 0;
    do begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      l++;
    end while (!resp_valid_o && l < 40);
    if (!resp_valid_o) chk("resp_timeout", 64'(resp_valid_o), 64'd1);
  endtask

  task automatic ack();
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] a, input logic [2:0] sz,
                        input int exp_lat, input logic exp_hit, input logic [2:0] exp_idx,
                        input logic exp_first, input logic exp_big);
    int l;
    issue(a, sz, l);
    chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
    chk({tag, "_hit"}, 64'(resp_hit_o), 64'(exp_hit));
    if (exp_hit) begin
      chk({tag, "_idx"}, 64'(resp_idx_o), 64'(exp_idx));
      chk({tag, "_first"}, 64'(resp_first_o), 64'(exp_first));
      chk({tag, "_big"}, 64'(resp_big_o), 64'(exp_big));
    end
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni       = 1'b0;
    flush_i      = 1'b0;
    wr_valid_i   = 1'b0;
    wr_start_i   = '0;
    wr_end_i     = '0;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_size_i   = 3'd1;
    resp_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Reset state
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_resp_hit", 64'(resp_hit_o), 64'd0);
    chk("rst_resp_idx", 64'(resp_idx_o), 64'd0);

    // Single range, overlap boundaries and size decode
    wr(32'h1000, 32'h1013);
    chk("one_count", 64'(count_o), 64'd1);
    lookup("mid4",    32'h1004, 3'd4, 2, 1'b1, 3'd0, 1'b0, 1'b0);
    lookup("start1",  32'h1000, 3'd1, 2, 1'b1, 3'd0, 1'b1, 1'b0);
    lookup("below4",  32'h0FFE, 3'd4, 2, 1'b1, 3'd0, 1'b0, 1'b0);
    lookup("miss4",   32'h0FFC, 3'd4, 2, 1'b0, 3'd0, 1'b0, 1'b0);
    lookup("size3",   32'h0FFF, 3'd3, 2, 1'b0, 3'd0, 1'b0, 1'b0);
    lookup("endbyte", 32'h1013, 3'd2, 2, 1'b1, 3'd0, 1'b0, 1'b0);

    // Nine writes into eight slots: oldest overwritten, count saturates
    flush_pulse();
    chk("flush_count", 64'(count_o), 64'd0);
    for (int i = 0; i < 9; i++) wr(32'h2000 + 32'h100 * i, 32'h200F + 32'h100 * i);
    chk("full_count", 64'(count_o), 64'd8);
    lookup("evicted", 32'h2004, 3'd1, 9, 1'b0, 3'd0, 1'b0, 1'b0);
    lookup("newest",  32'h2804, 3'd1, 2, 1'b1, 3'd0, 1'b0, 1'b0);
    lookup("second",  32'h2704, 3'd1, 3, 1'b1, 3'd7, 1'b0, 1'b0);

    // Big tagging, dropped inverted write, newest-first wrap order
    wr(32'h3000, 32'h3080);
    chk("big_count", 64'(count_o), 64'd8);
    lookup("big",     32'h3040, 3'd2, 2, 1'b1, 3'd1, 1'b0, 1'b1);
    wr(32'h5000, 32'h4000);
    chk("inv_count", 64'(count_o), 64'd8);
    lookup("inv_ptr", 32'h3040, 3'd1, 2, 1'b1, 3'd1, 1'b0, 1'b1);
    lookup("inv_gone",32'h4800, 3'd1, 9, 1'b0, 3'd0, 1'b0, 1'b0);
    wr(32'h6000, 32'h6063);
    lookup("len100",  32'h6000, 3'd1, 2, 1'b1, 3'd2, 1'b1, 1'b0);
    wr(32'h7000, 32'h7064);
    lookup("len101",  32'h7064, 3'd4, 2, 1'b1, 3'd3, 1'b0, 1'b1);
    lookup("wrap",    32'h2704, 3'd1, 6, 1'b1, 3'd7, 1'b0, 1'b0);
    lookup("pastend", 32'h7065, 3'd4, 9, 1'b0, 3'd0, 1'b0, 1'b0);

    // Empty table and response hold under backpressure
    flush_pulse();
    issue(32'h1234, 3'd1, lat);
    chk("empty_lat", 64'(lat), 64'd1);
    chk("empty_hit", 64'(resp_hit_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("hold_valid", 64'(resp_valid_o), 64'd1);
      chk("hold_hit", 64'(resp_hit_o), 64'd0);
      chk("hold_ready", 64'(req_ready_o), 64'd0);
    end
    ack();
    chk("post_ack_ready", 64'(req_ready_o), 64'd1);
    chk("post_ack_valid", 64'(resp_valid_o), 64'd0);

    // Flush aborts an in-flight scan three cycles after acceptance
    for (int i = 0; i < 8; i++) wr(32'h2000 + 32'h100 * i, 32'h200F + 32'h100 * i);
    chk("refill_count", 64'(count_o), 64'd8);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = 32'h8000;
    req_size_i  = 3'd4;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("abort_pre_valid", 64'(resp_valid_o), 64'd0);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("abort_valid", 64'(resp_valid_o), 64'd1);
    chk("abort_hit", 64'(resp_hit_o), 64'd0);
    chk("abort_count", 64'(count_o), 64'd0);
    ack();

    // Flush while a hit is held keeps the response
    wr(32'hA000, 32'hA00F);
    issue(32'hA000, 3'd1, lat);
    chk("held_lat", 64'(lat), 64'd2);
    flush_pulse();
    chk("held_valid", 64'(resp_valid_o), 64'd1);
    chk("held_hit", 64'(resp_hit_o), 64'd1);
    chk("held_first", 64'(resp_first_o), 64'd1);
    chk("held_count", 64'(count_o), 64'd0);
    ack();

    // Write coinciding with flush is dropped
    @(negedge clk_i);
    flush_i    = 1'b1;
    wr_valid_i = 1'b1;
    wr_start_i = 32'h9000;
    wr_end_i   = 32'h9003;
    @(negedge clk_i);
    flush_i    = 1'b0;
    wr_valid_i = 1'b0;
    chk("wrflush_count", 64'(count_o), 64'd0);
    lookup("wrflush", 32'h9000, 3'd1, 1, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
